// File: rtl/sc_sobol_pkg.sv
// Shared definitions for the Sobol stochastic-computing multiplier stream.
// Provides the control-state encoding and the bit-level helper functions.
// The helpers work on 32-bit containers. Callers zero-extend their operands
// into the container and size-cast the result back to the width they need.
package sc_sobol_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FN_W = 32;

    // Binary-reflected Gray code of v.
    function automatic logic [FN_W-1:0] gray_f(input logic [FN_W-1:0] v);
        return v ^ (v >> 1);
    endfunction

    // Reverse the low w bits of v. Bits at and above w come back as zero.
    // The result is built by shifting, so no bit is selected by a variable index.
    function automatic logic [FN_W-1:0] bitrev_f(input logic [FN_W-1:0] v, input int w);
        logic [FN_W-1:0] r;
        logic [FN_W-1:0] t;
        r = 32'd0;
        t = v;
        for (int i = 0; i < FN_W; i++) begin
            if (i < w) begin
                r = (r << 1) | {31'd0, t[0]};
                t = t >> 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Number of set bits in v.
    function automatic logic [FN_W-1:0] popcount_f(input logic [FN_W-1:0] v);
        logic [FN_W-1:0] cnt;
        logic [FN_W-1:0] t;
        cnt = 32'd0;
        t   = v;
        for (int i = 0; i < FN_W; i++) begin
            cnt = cnt + {31'd0, t[0]};
            t   = t >> 1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sobol_dim_gen.sv
// Purely combinational generator of the two Sobol dimensions for one index.
//   index : stream index (LOG_LEN+1 bits, covers extended length)
//   ext   : 1 selects stream length 2^(LOG_LEN+1), 0 selects 2^LOG_LEN
//   s1    : dimension 1, bit-reversed Gray code of index over SOBOL_W bits
//   s2    : dimension 2, index scaled so that it spans the full SOBOL_W range
module sobol_dim_gen
    import sc_sobol_pkg::*;
#(
    parameter int SOBOL_W = 6,
    parameter int LOG_LEN = 5
) (
    input  logic [LOG_LEN:0]    index,
    input  logic                ext,
    output logic [SOBOL_W-1:0]  s1,
    output logic [SOBOL_W-1:0]  s2
);

    localparam int SH_BASE = SOBOL_W - LOG_LEN;
    localparam int SH_EXT  = SOBOL_W - LOG_LEN - 1;

    logic [FN_W-1:0] index_s;

    // Derive both Sobol values. The linear dimension shifts one place less when the stream is doubled.
    always_comb begin
        index_s = FN_W'(index);
        s1      = SOBOL_W'(bitrev_f(gray_f(index_s), SOBOL_W));
        if (ext) begin
            s2 = SOBOL_W'(index_s << SH_EXT);
        end else begin
            s2 = SOBOL_W'(index_s << SH_BASE);
        end
    end

endmodule

// File: rtl/sobol_sc_mul_stream.sv
// Sobol-sequence stochastic-computing multiplier stream generator.
// The block accepts two unsigned operands and turns each one into a unipolar
// bitstream. It emits LANES AND-ed product bits per beat and then returns the
// popcount of the whole stream as the product estimate.
//   clk, rst             : clock, asynchronous active-high reset
//   clear                : synchronous abort to IDLE (res_count is kept)
//   in_valid/in_ready    : operand handshake (in_a, in_b, in_extend)
//   bs_valid/bs_ready    : product-bit beats (bs_data, bs_last)
//   res_valid/res_ready  : popcount result handshake (res_count)
module sobol_sc_mul_stream
    import sc_sobol_pkg::*;
#(
    parameter int SOBOL_W = 6,
    parameter int LOG_LEN = 5,
    parameter int LANES   = 4,
    parameter int CNT_W   = LOG_LEN + 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SOBOL_W-1:0]  in_a,
    input  logic [SOBOL_W-1:0]  in_b,
    input  logic                in_extend,
    output logic                bs_valid,
    input  logic                bs_ready,
    output logic [LANES-1:0]    bs_data,
    output logic                bs_last,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [CNT_W-1:0]    res_count
);

    localparam int IDX_W = LOG_LEN + 1;
    // Index of the final beat for the base and the extended stream lengths.
    localparam logic [IDX_W-1:0] LAST_BASE = IDX_W'((1 << LOG_LEN) - LANES);
    localparam logic [IDX_W-1:0] LAST_EXT  = IDX_W'((1 << (LOG_LEN + 1)) - LANES);
    localparam logic [IDX_W-1:0] IDX_STEP  = IDX_W'(LANES);

    state_e               state_q, state_d;
    logic [SOBOL_W-1:0]   a_q, a_d;
    logic [SOBOL_W-1:0]   b_q, b_d;
    logic                 ext_q, ext_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     res_q, res_d;

    logic [IDX_W-1:0]     lane_idx_s [LANES];
    logic [SOBOL_W-1:0]   s1_s [LANES];
    logic [SOBOL_W-1:0]   s2_s [LANES];
    logic [LANES-1:0]     prod_s;
    logic [CNT_W-1:0]     beat_ones_s;
    logic                 last_beat_s;

    // Each lane computes the product bit for stream index idx+k. The lanes
    // depend only on registered state, so a stalled beat stays stable.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_idx_s[k] = idx_q + IDX_W'(k);

        sobol_dim_gen #(
            .SOBOL_W (SOBOL_W),
            .LOG_LEN (LOG_LEN)
        ) u_dim (
            .index (lane_idx_s[k]),
            .ext   (ext_q),
            .s1    (s1_s[k]),
            .s2    (s2_s[k])
        );

        assign prod_s[k] = (a_q > s1_s[k]) & (b_q > s2_s[k]);
    end

    // Beat popcount and final-beat detection.
    always_comb begin
        beat_ones_s = CNT_W'(popcount_f(FN_W'(prod_s)));
        if (ext_q) begin
            last_beat_s = (idx_q == LAST_EXT);
        end else begin
            last_beat_s = (idx_q == LAST_BASE);
        end
    end

    // Next-state logic: the operand, stream and result phases, with clear taking priority.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ext_d   = ext_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        res_d   = res_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    ext_d   = in_extend;
                    idx_d   = {IDX_W{1'b0}};
                    acc_d   = {CNT_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bs_ready) begin
                    acc_d = acc_q + beat_ones_s;
                    if (last_beat_s) begin
                        res_d   = acc_q + beat_ones_s;
                        idx_d   = {IDX_W{1'b0}};
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_STEP;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort: drop any handshake of this cycle. Operands and the last result are kept.
        if (clear) begin
            state_d = ST_IDLE;
            a_d     = a_q;
            b_d     = b_q;
            ext_d   = ext_q;
            idx_d   = {IDX_W{1'b0}};
            acc_d   = {CNT_W{1'b0}};
            res_d   = res_q;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= {SOBOL_W{1'b0}};
            b_q     <= {SOBOL_W{1'b0}};
            ext_q   <= 1'b0;
            idx_q   <= {IDX_W{1'b0}};
            acc_q   <= {CNT_W{1'b0}};
            res_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ext_q   <= ext_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        bs_valid  = (state_q == ST_RUN);
        res_valid = (state_q == ST_DONE);
        bs_data   = prod_s;
        bs_last   = (state_q == ST_RUN) & last_beat_s;
        res_count = res_q;
    end

endmodule

// File: tb/tb_sobol_sc_mul_stream.sv
// Scoreboard bench for sobol_sc_mul_stream (W=6, LOG_LEN=5, LANES=4).
// Stimulus queues hand-computed beats and results; a monitor pops and compares.
module tb_sobol_sc_mul_stream;

    localparam int W     = 6;
    localparam int LL    = 5;
    localparam int LANES = 4;
    localparam int CNT_W = LL + 2;

    typedef struct packed {
        logic [LANES-1:0] d;
        logic             last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      in_a = 6'd0;
    logic [W-1:0]      in_b = 6'd0;
    logic              in_extend = 1'b0;
    logic              bs_valid;
    logic              bs_ready = 1'b0;
    logic [LANES-1:0]  bs_data;
    logic              bs_last;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [CNT_W-1:0]  res_count;

    beat_t             exp_beats[$];
    logic [CNT_W-1:0]  exp_res[$];
    int                chk_cnt = 0;
    int                pass_cnt = 0;
    int                res_seen = 0;

    sobol_sc_mul_stream #(
        .SOBOL_W (W),
        .LOG_LEN (LL),
        .LANES   (LANES),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_extend (in_extend),
        .bs_valid  (bs_valid),
        .bs_ready  (bs_ready),
        .bs_data   (bs_data),
        .bs_last   (bs_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_count (res_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: checks handshakes against the queues, stability under stall, and in_ready while busy.
    initial begin
        beat_t            e;
        logic [CNT_W-1:0] r;
        logic             stall_d = 1'b0;
        logic             stall_r = 1'b0;
        logic [LANES-1:0] held_d = 4'd0;
        logic [CNT_W-1:0] held_r = 7'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_d = 1'b0;
                stall_r = 1'b0;
            end else begin
                if (bs_valid || res_valid) chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
                if (bs_valid && stall_d) chk("bs_data_hold", {28'd0, bs_data}, {28'd0, held_d});
                if (res_valid && stall_r) chk("res_count_hold", {25'd0, res_count}, {25'd0, held_r});
                stall_d = bs_valid && !bs_ready;
                held_d  = bs_data;
                stall_r = res_valid && !res_ready;
                held_r  = res_count;
                if (bs_valid && bs_ready) begin
                    if (exp_beats.size() == 0) begin
                        chk("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        e = exp_beats.pop_front();
                        chk("bs_data", {28'd0, bs_data}, {28'd0, e.d});
                        chk("bs_last", {31'd0, bs_last}, {31'd0, e.last});
                    end
                end
                if (res_valid && res_ready) begin
                    if (exp_res.size() == 0) begin
                        chk("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        r = exp_res.pop_front();
                        chk("res_count", {25'd0, res_count}, {25'd0, r});
                    end
                    res_seen++;
                end
            end
        end
    end

    // One complete operation. The first n_hi beats carry pat_hi and the rest carry pat_lo.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic ext,
                       input int beats, input logic [3:0] pat_hi, input int n_hi,
                       input logic [3:0] pat_lo, input int cnt, input bit bp);
        beat_t e;
        int    start;
        for (int j = 0; j < beats; j++) begin
            e.d    = (j < n_hi) ? pat_hi : pat_lo;
            e.last = (j == beats - 1);
            exp_beats.push_back(e);
        end
        exp_res.push_back(CNT_W'(cnt));
        in_a      = a;
        in_b      = b;
        in_extend = ext;
        in_valid  = 1'b1;
        bs_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        res_ready = bp ? 1'b0 : 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_a      = ~a;
        in_b      = ~b;
        in_extend = ~ext;
        @(negedge clk);
        chk("first_beat_valid", {31'd0, bs_valid}, 32'd1);
        start = res_seen;
        for (int c = 0; c < 600 && res_seen == start; c++) begin
            @(posedge clk);
            #1;
            if (bp) begin
                bs_ready  = 1'($urandom_range(0, 1));
                res_ready = 1'($urandom_range(0, 1));
            end
        end
        chk("run_completed", {31'd0, res_seen != start}, 32'd1);
        bs_ready  = 1'b1;
        res_ready = 1'b1;
    endtask

    initial begin
        beat_t e;
        // Check the outputs while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_bs_valid", {31'd0, bs_valid}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_count", {25'd0, res_count}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Start a run, hold it stalled, then assert reset in the middle of it.
        in_a = 6'd63; in_b = 6'd63; in_extend = 1'b0; in_valid = 1'b1; bs_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_bs_valid", {31'd0, bs_valid}, 32'd0);
        chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_res_count", {25'd0, res_count}, 32'd0);
        @(posedge clk);
        #1;

        // Directed runs. Patterns are listed as bit3..bit0 = p(idx+3)..p(idx).
        run(6'd32, 6'd32, 1'b0, 8,  4'b1001, 4, 4'b0000, 8,  1'b0);
        run(6'd63, 6'd63, 1'b0, 8,  4'b1111, 8, 4'b0000, 32, 1'b0);
        run(6'd0,  6'd63, 1'b0, 8,  4'b0000, 8, 4'b0000, 0,  1'b0);
        run(6'd32, 6'd32, 1'b1, 16, 4'b1001, 8, 4'b0000, 16, 1'b0);
        run(6'd32, 6'd32, 1'b0, 8,  4'b1001, 4, 4'b0000, 8,  1'b1);

        // Beats 0..2 complete normally. Beat 3 completes with clear high.
        for (int j = 0; j < 4; j++) begin
            e.d = 4'b1001; e.last = 1'b0;
            exp_beats.push_back(e);
        end
        in_a = 6'd32; in_b = 6'd32; in_extend = 1'b0; in_valid = 1'b1;
        bs_ready = 1'b1; res_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        chk("clear_in_ready", {31'd0, in_ready}, 32'd1);
        chk("clear_bs_valid", {31'd0, bs_valid}, 32'd0);
        chk("clear_res_valid", {31'd0, res_valid}, 32'd0);
        chk("clear_res_held", {25'd0, res_count}, 32'd8);
        @(posedge clk);
        #1;
        run(6'd63, 6'd63, 1'b0, 8, 4'b1111, 8, 4'b0000, 32, 1'b0);

        repeat (3) @(posedge clk);
        chk("beats_drained", exp_beats.size(), 32'd0);
        chk("results_drained", exp_res.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
